// File: rtl/cube_input_sequencer_pkg.sv
// cube_state_pkg: colour codes, facelet geometry, centre table and sequencer states
package cube_state_pkg;
  localparam int NUM_FACELETS = 54;
  localparam int STATE_W = 3 * NUM_FACELETS;
  localparam logic [5:0] LAST_IDX = 6'd53;
  localparam logic [2:0] C_NONE = 3'b000, C_ILLEGAL = 3'b001, C_G = 3'b010, C_B = 3'b011;
  localparam logic [2:0] C_R = 3'b100, C_O = 3'b101, C_Y = 3'b110, C_W = 3'b111;
  localparam logic [5:0] CENTRE_IDX [6] = '{6'd4, 6'd13, 6'd22, 6'd31, 6'd40, 6'd49};
  localparam logic [2:0] CENTRE_COL [6] = '{C_W, C_R, C_G, C_Y, C_O, C_B};
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_STORE, S_RELEASE, S_CHECK, S_DONE, S_ERR} state_t;
  function automatic logic is_centre(input logic [5:0] i);
    is_centre = 1'b0;
    for (int f = 0; f < 6; f++) is_centre = is_centre | (i == CENTRE_IDX[f]);
  endfunction
  function automatic logic [STATE_W-1:0] centre_state();
    centre_state = '0;
    for (int f = 0; f < 6; f++) centre_state[3*int'(CENTRE_IDX[f]) +: 3] = CENTRE_COL[f];
  endfunction
endpackage

// File: rtl/cube_input_sequencer_if.sv
// cube_input_sequencer_if: control, chooser and result signals of the sequencer
interface cube_input_sequencer_if;
  import cube_state_pkg::*;
  logic start;
  logic undo;
  logic [2:0] chooser_colour;
  logic chooser_active;
  logic [5:0] facelet_idx;
  logic [STATE_W-1:0] cube_state;
  logic busy;
  logic state_valid;
  logic count_error;
  modport master(output start, undo, chooser_colour,
                 input chooser_active, facelet_idx, cube_state, busy, state_valid, count_error);
  modport slave(input start, undo, chooser_colour,
                output chooser_active, facelet_idx, cube_state, busy, state_valid, count_error);
endinterface

// File: rtl/cube_input_sequencer_colour_tally.sv
// colour_tally: serial per-colour counters; pass reflects counts including the current input
module colour_tally
  import cube_state_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] colour,
  output logic       pass
);
  logic [5:0] cnt_q [6];
  logic [5:0] cnt_d [6];
  always_comb begin
    pass = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cnt_d[c] = clr ? 6'd0 : cnt_q[c] + 6'(en && colour == C_G + 3'(c));
      pass = pass && cnt_d[c] == 6'd9;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int c = 0; c < 6; c++) cnt_q[c] <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/cube_input_sequencer.sv
// cube_input_sequencer: walks the 54 facelets through the colour chooser and validates the colour counts
module cube_input_sequencer
  import cube_state_pkg::*;
#(
  parameter int GAP_CYCLES     = 15000,
  parameter int TIMEOUT_CYCLES = 0
) (
  input logic clk,
  input logic rst,
  cube_input_sequencer_if.slave bus
);
  localparam int MAXV = GAP_CYCLES > TIMEOUT_CYCLES ? (GAP_CYCLES > 54 ? GAP_CYCLES : 54)
                                                    : (TIMEOUT_CYCLES > 54 ? TIMEOUT_CYCLES : 54);
  localparam int CW = $clog2(MAXV + 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d, prev_idx, next_idx;
  logic [STATE_W-1:0] cube_q, cube_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] colour_q, colour_d;
  logic back_q, back_d;
  logic active_q, active_d, busy_q, busy_d, valid_q, valid_d, err_q, err_d;
  logic tally_pass;
  assign prev_idx = is_centre(idx_q - 6'd1) ? idx_q - 6'd2 : idx_q - 6'd1;
  assign next_idx = is_centre(idx_q + 6'd1) ? idx_q + 6'd2 : idx_q + 6'd1;
  colour_tally u_tally (
    .clk(clk), .rst(rst), .clr(state_q != S_CHECK), .en(state_q == S_CHECK),
    .colour(cube_q[3*int'(cnt_q[5:0]) +: 3]), .pass(tally_pass)
  );
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    cube_d = cube_q;
    cnt_d = cnt_q + CW'(1);
    colour_d = colour_q;
    back_d = back_q;
    if (bus.start) begin
      state_d = S_ARM;
      idx_d = '0;
      cube_d = centre_state();
      cnt_d = '0;
    end else case (state_q)
      S_ARM:
        if (bus.undo && idx_q != '0) begin
          state_d = S_RELEASE;
          idx_d = prev_idx;
          cube_d[3*int'(prev_idx) +: 3] = C_NONE;
          back_d = 1'b1;
          cnt_d = '0;
        end else if (bus.chooser_colour > C_ILLEGAL) begin
          state_d = S_STORE;
          colour_d = bus.chooser_colour;
        end else if (TIMEOUT_CYCLES > 0 && cnt_q == TMO_LAST) state_d = S_IDLE;
      S_STORE: begin
        cube_d[3*int'(idx_q) +: 3] = colour_q;
        back_d = 1'b0;
        cnt_d = '0;
        state_d = S_RELEASE;
      end
      S_RELEASE:
        if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          state_d = (!back_q && idx_q == LAST_IDX) ? S_CHECK : S_ARM;
          idx_d = (back_q || idx_q == LAST_IDX) ? idx_q : next_idx;
        end
      S_CHECK: if (cnt_q[5:0] == LAST_IDX) state_d = tally_pass ? S_DONE : S_ERR;
      default: ;
    endcase
    active_d = state_d == S_ARM;
    busy_d = state_d inside {S_ARM, S_STORE, S_RELEASE, S_CHECK};
    valid_d = state_d == S_DONE;
    err_d = state_d == S_ERR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= '0;
      cube_q <= '0;
      cnt_q <= '0;
      colour_q <= '0;
      back_q <= 1'b0;
      active_q <= 1'b0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      cube_q <= cube_d;
      cnt_q <= cnt_d;
      colour_q <= colour_d;
      back_q <= back_d;
      active_q <= active_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      err_q <= err_d;
    end
  assign bus.chooser_active = active_q;
  assign bus.facelet_idx = idx_q;
  assign bus.cube_state = cube_q;
  assign bus.busy = busy_q;
  assign bus.state_valid = valid_q;
  assign bus.count_error = err_q;
endmodule

// File: tb/tb_cube_input_sequencer.sv
// tb_cube_input_sequencer: randomized capture sessions checked every cycle against a timed behavioural model
module tb_cube_input_sequencer;
  localparam int GAP = 4;
  localparam int TMO = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  cube_input_sequencer_if bus();
  cube_input_sequencer #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, pulses = 0;
  logic [2:0] m_cube [54];
  logic e_active = 0, e_busy = 0, e_valid = 0, e_err = 0;
  int e_idx = 0;
  logic [2:0] face_col [6] = '{3'd7, 3'd4, 3'd2, 3'd6, 3'd5, 3'd3};
  logic [2:0] seq [48];
  always @(posedge bus.chooser_active) pulses++;
  function automatic logic [161:0] mvec();
    logic [161:0] v;
    for (int k = 0; k < 54; k++) v[3*k +: 3] = m_cube[k];
    return v;
  endfunction
  function automatic bit centre(int k);
    return k % 9 == 4;
  endfunction
  function automatic int next_of(int k);
    return centre(k + 1) ? k + 2 : k + 1;
  endfunction
  function automatic int prev_of(int k);
    return centre(k - 1) ? k - 2 : k - 1;
  endfunction
  function automatic bit counts_ok();
    int n [8];
    for (int c = 0; c < 8; c++) n[c] = 0;
    for (int k = 0; k < 54; k++) n[m_cube[k]]++;
    for (int c = 2; c < 8; c++) if (n[c] != 9) return 0;
    return 1;
  endfunction
  always @(negedge clk) begin
    n_chk++;
    if ({bus.chooser_active, bus.facelet_idx, bus.busy, bus.state_valid, bus.count_error, bus.cube_state}
        !== {e_active, 6'(e_idx), e_busy, e_valid, e_err, mvec()}) begin
      n_fail++;
      $display("FAIL cycle_compare @%0t: got act=%b idx=%0d busy=%b ok=%b err=%b cube=%h; want act=%b idx=%0d busy=%b ok=%b err=%b cube=%h",
               $time, bus.chooser_active, bus.facelet_idx, bus.busy, bus.state_valid, bus.count_error, bus.cube_state,
               e_active, e_idx, e_busy, e_valid, e_err, mvec());
    end
  end
  task automatic chk(input string name, input logic [161:0] act, input logic [161:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 54; k++) m_cube[k] = centre(k) ? face_col[k / 9] : 3'd0;
    e_idx = 0;
    e_active = 1;
    e_busy = 1;
    e_valid = 0;
    e_err = 0;
  endtask
  task automatic answer(input logic [2:0] c);
    repeat ($urandom_range(0, 6)) begin
      bus.chooser_colour = 3'($urandom_range(0, 1));
      tick();
    end
    bus.chooser_colour = c;
    tick();
    bus.chooser_colour = 3'd0;
    e_active = 0;
    tick();
    m_cube[e_idx] = c;
    repeat (GAP) tick();
    if (e_idx == 53) begin
      repeat (54) tick();
      e_busy = 0;
      e_valid = counts_ok();
      e_err = !counts_ok();
    end else begin
      e_idx = next_of(e_idx);
      e_active = 1;
    end
  endtask
  task automatic do_undo(input logic [2:0] c);
    bus.undo = 1'b1;
    bus.chooser_colour = c;
    tick();
    bus.undo = 1'b0;
    bus.chooser_colour = 3'd0;
    e_idx = prev_of(e_idx);
    m_cube[e_idx] = 3'd0;
    e_active = 0;
    repeat (GAP) tick();
    e_active = 1;
  endtask
  task automatic build_seq(input bit bad);
    int j;
    logic [2:0] t;
    for (int i = 0; i < 48; i++) seq[i] = 3'(2 + i / 8);
    for (int i = 47; i > 0; i--) begin
      j = $urandom_range(0, i);
      t = seq[i];
      seq[i] = seq[j];
      seq[j] = t;
    end
    if (bad) for (int i = 0; i < 48; i++) if (seq[i] == 3'd2) begin
      seq[i] = 3'd4;
      break;
    end
  endtask
  task automatic capture_seq();
    for (int i = 0; i < 48; i++) answer(seq[i]);
  endtask
  initial begin
    logic [161:0] solved;
    for (int k = 0; k < 54; k++) m_cube[k] = 3'd0;
    for (int k = 0; k < 54; k++) solved[3*k +: 3] = face_col[k / 9];
    bus.start = 1'b0;
    bus.undo = 1'b0;
    bus.chooser_colour = 3'd0;
    repeat (3) tick();
    chk("reset_outputs", {bus.chooser_active, bus.busy, bus.state_valid, bus.count_error, bus.facelet_idx, bus.cube_state}, '0);
    rst = 1'b0;
    tick();
    pulses = 0;
    do_start();
    for (int k = 0; k < 54; k++) if (!centre(k)) answer(face_col[k / 9]);
    chk("solved_pulses", 162'(pulses), 162'd48);
    chk("solved_valid", {bus.state_valid, bus.count_error}, 2'b10);
    chk("solved_cube", bus.cube_state, solved);
    do_start();
    for (int i = 0; i < 3; i++) answer(3'($urandom_range(2, 7)));
    answer(3'b010);
    chk("centre_skip_idx", bus.facelet_idx, 6'd5);
    chk("centre_slot4", bus.cube_state[14:12], 3'b111);
    chk("slot3_green", bus.cube_state[11:9], 3'b010);
    answer(3'b100);
    chk("idx_after_5", bus.facelet_idx, 6'd6);
    chk("slot5_red", bus.cube_state[17:15], 3'b100);
    do_undo(3'b110);
    chk("undo_idx", bus.facelet_idx, 6'd5);
    chk("undo_slot5_clear", bus.cube_state[17:15], 3'b000);
    chk("undo_rearm", bus.chooser_active, 1'b1);
    bus.chooser_colour = 3'b001;
    repeat (TMO - 1) tick();
    chk("illegal_still_arm", {bus.chooser_active, bus.busy}, 2'b11);
    tick();
    e_active = 0;
    e_busy = 0;
    bus.chooser_colour = 3'd0;
    chk("timeout_idle", {bus.chooser_active, bus.busy}, 2'b00);
    chk("timeout_cube_kept", bus.cube_state[17:9], 9'b000_111_010);
    repeat (3) tick();
    do_start();
    build_seq(1'b0);
    for (int i = 0; i < 20; i++) answer(seq[i]);
    build_seq(1'b1);
    do_start();
    capture_seq();
    chk("bad_count_flags", {bus.state_valid, bus.count_error, bus.busy}, 3'b010);
    build_seq(1'b0);
    do_start();
    capture_seq();
    chk("random_valid_flags", {bus.state_valid, bus.count_error, bus.busy}, 3'b100);
    do_start();
    answer(3'($urandom_range(2, 7)));
    bus.chooser_colour = 3'b011;
    tick();
    bus.chooser_colour = 3'd0;
    e_active = 0;
    tick();
    m_cube[e_idx] = 3'b011;
    tick();
    #2;
    rst = 1'b1;
    e_busy = 0;
    e_idx = 0;
    for (int k = 0; k < 54; k++) m_cube[k] = 3'd0;
    #1;
    chk("async_rst_outputs", {bus.chooser_active, bus.busy, bus.state_valid, bus.count_error, bus.facelet_idx, bus.cube_state}, '0);
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("idle_after_rst", {bus.chooser_active, bus.busy}, 2'b00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
